// File: rtl/div_pkg.sv
// div_pkg: shared width, counter size and FSM encoding for seq_signed_divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: request/result bundle between a requester and the divider.
interface seq_signed_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_WIDTH
)(
  input  logic [W:0] rem,
  input  logic       dvd_msb,
  input  logic [W:0] divisor,
  output logic [W:0] rem_next,
  output logic       q_bit
);

  logic [W+1:0] shifted;

  // trial >= 0 is evaluated as a compare on the widened shift so no bit is lost
  always_comb begin
    shifted  = {rem, dvd_msb};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? (shifted[W:0] - divisor) : shifted[W:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: 32-bit signed restoring divider, one quotient bit per cycle.
// Optional build macro SEQ_DIVIDER_OUT_REG_EN adds one output register stage.
module seq_signed_divider
  import div_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  seq_signed_divider_if.slave        bus
);

  localparam int unsigned W = DIV_WIDTH;
  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(W - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_ONE   = DIV_CNT_W'(1);

  div_state_e           state;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic                 sign_q;
  logic                 sign_r;
  logic                 dbz;
  logic [W-1:0]         dvd;
  logic [W:0]           rem;
  logic [W:0]           babs;
  logic [DIV_CNT_W-1:0] count;

  logic                 busy_r;
  logic                 done_r;
  logic [W-1:0]         quo_r;
  logic [W-1:0]         rem_r;
  logic                 dbz_r;

  logic [W:0]           rem_next;
  logic                 q_bit;
  logic [W-1:0]         fix_quo;
  logic [W-1:0]         fix_rem;

  div_step #(.W(W)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[W-1]),
    .divisor  (babs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // divide-by-zero overrides whatever the iterations produced
  always_comb begin
    fix_quo = sign_q ? -dvd : dvd;
    fix_rem = sign_r ? -rem[W-1:0] : rem[W-1:0];
    if (dbz) begin
      fix_quo = '1;
      fix_rem = a_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dbz    <= 1'b0;
      dvd    <= '0;
      rem    <= '0;
      babs   <= '0;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          sign_q <= a_reg[W-1] ^ b_reg[W-1];
          sign_r <= a_reg[W-1];
          dbz    <= (b_reg == '0);
          // |-2^31| = 2^31 is still exact as an unsigned W-bit value
          dvd    <= a_reg[W-1] ? -a_reg : a_reg;
          babs   <= {1'b0, (b_reg[W-1] ? -b_reg : b_reg)};
          rem    <= '0;
          count  <= '0;
          state  <= ITER;
        end
        ITER: begin
          rem   <= rem_next;
          dvd   <= {dvd[W-2:0], q_bit};
          count <= count + CNT_ONE;
          if (count == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          quo_r  <= fix_quo;
          rem_r  <= fix_rem;
          dbz_r  <= dbz;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;

`ifdef SEQ_DIVIDER_OUT_REG_EN
  logic         done_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] rem_q;
  logic         dbz_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= done_r;
      if (done_r) begin
        quo_q <= quo_r;
        rem_q <= rem_r;
        dbz_q <= dbz_r;
      end
    end
  end

  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and random divisions checked against an arithmetic model.
`timescale 1ns/1ps
module tb_seq_signed_divider;
  import div_pkg::*;

`ifdef SEQ_DIVIDER_OUT_REG_EN
  localparam int LAT = DIV_WIDTH + 3;
`else
  localparam int LAT = DIV_WIDTH + 2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_signed_divider_if #(.WIDTH(DIV_WIDTH)) bus ();

  seq_signed_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    longint sa;
    longint sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input int inject_at);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          cyc;
    int          gaps;
    ref_div(ta, tbv, eq, er, ez);
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tbv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc  = 0;
    gaps = 0;
    while (bus.done !== 1'b1 && cyc < LAT + 20) begin
      if (bus.busy !== 1'b1 && cyc < DIV_WIDTH + 2) gaps++;
      bus.start = (cyc == inject_at);
      if (cyc == inject_at) begin
        bus.a = 32'd5;
        bus.b = 32'd1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "/latency"}, cyc, LAT);
    chk({tag, "/quotient"}, bus.quotient, eq);
    chk({tag, "/remainder"}, bus.remainder, er);
    chk({tag, "/dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ez});
    chk({tag, "/busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "/busy_gaps"}, gaps, 32'd0);
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "/hold_q"}, bus.quotient, eq);
  endtask

  task automatic quiet_window(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    chk({tag, "/no_done"}, pulses, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/busy", {31'd0, bus.busy}, 32'd0);
    chk("rst/done", {31'd0, bus.done}, 32'd0);
    chk("rst/quotient", bus.quotient, 32'd0);
    chk("rst/remainder", bus.remainder, 32'd0);
    chk("rst/dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("30/6", 32'd30, 32'd6, -1);
    run_op("-28/-4", -32'sd28, -32'sd4, -1);
    run_op("-40/10", -32'sd40, 32'd10, -1);
    run_op("7/-2", 32'd7, -32'sd2, -1);
    run_op("-7/2", -32'sd7, 32'd2, -1);
    run_op("1234/0", 32'd1234, 32'd0, -1);
    run_op("99/1", 32'd99, 32'd1, -1);
    run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("min/1", 32'h8000_0000, 32'd1, -1);
    run_op("ignored_start", 32'd30, 32'd6, 10);
    quiet_window("ignored_start", 45);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        1: rb = $urandom_range(0, 40) - 32'd20;
        2: begin
          ra = 32'h8000_0000;
          if ($urandom_range(0, 1) == 0) rb = 32'hFFFF_FFFF;
        end
        3: ra = $urandom_range(0, 2000) - 32'd1000;
        4: rb = 32'd0;
        default: ;
      endcase
      run_op("random", ra, rb, -1);
    end

    run_op("-5/0", -32'sd5, 32'd0, -1);
    @(negedge clk);
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort/busy", {31'd0, bus.busy}, 32'd0);
    chk("abort/done", {31'd0, bus.done}, 32'd0);
    chk("abort/quotient", bus.quotient, 32'd0);
    chk("abort/remainder", bus.remainder, 32'd0);
    chk("abort/dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet_window("abort", 45);
    run_op("1000/3", 32'd1000, 32'd3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
